// File: rtl/pic24_fetch_sequencer.sv
// PIC24 instruction-fetch sequencer: reset-vector load, req/ack fetch, and
// direct execution of BRA and two-word GOTO; every other opcode steps the PC.
module pic24_fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [7:0]  GOTO_OPC     = 8'h04,
  parameter logic [7:0]  BRA_OPC      = 8'h37
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [23:0] pc_addr_i,
  output logic        pc_inc_o,
  output logic        pc_load_o,
  output logic [15:0] pc_data_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [23:0] imem_rdata_i,
  output logic [23:0] ir_o,
  output logic        ir_valid_o,
  input  logic        stall_i,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_LOAD   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] ir_q;
  logic [15:0] target_q;
  logic        illegal_q;
  logic        capture_ir, capture_target, set_illegal;
  logic [15:0] bra_target;
  logic        unused_pc_hi;

  // Sign-extended word offset doubled into a byte offset; only the low 16 bits matter.
  assign bra_target   = pc_addr_i[15:0] + 16'd2 + {ir_q[14:0], 1'b0};
  assign unused_pc_hi = ^pc_addr_i[23:16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RST;
      ir_q      <= '0;
      target_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_ir)     ir_q      <= imem_rdata_i;
      if (capture_target) target_q  <= {ir_q[15:1], 1'b0};
      if (set_illegal)    illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_inc_o       = 1'b0;
    pc_load_o      = 1'b0;
    pc_data_o      = '0;
    imem_req_o     = 1'b0;
    ir_valid_o     = 1'b0;
    capture_ir     = 1'b0;
    capture_target = 1'b0;
    set_illegal    = 1'b0;
    unique case (state_q)
      ST_RST: begin
        // Gated by reset so no load reaches the PC while reset is held.
        pc_load_o = rst_ni;
        pc_data_o = rst_ni ? RESET_VECTOR : '0;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          capture_ir = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ir_valid_o = 1'b1;
        if (!stall_i) begin
          if (ir_q[23:16] == BRA_OPC) begin
            pc_load_o = 1'b1;
            pc_data_o = bra_target;
            state_d   = ST_FETCH;
          end else if (ir_q[23:16] == GOTO_OPC) begin
            pc_inc_o       = 1'b1;
            capture_target = 1'b1;
            state_d        = ST_FETCH2;
          end else begin
            pc_inc_o = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_FETCH2: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          set_illegal = (imem_rdata_i[6:0] != 7'd0);
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pc_load_o = 1'b1;
        pc_data_o = target_q;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  assign ir_o      = ir_q;
  assign illegal_o = illegal_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pic24_fetch_sequencer.sv
// Bench for pic24_fetch_sequencer: a flag-based behavioural model of the fetch
// rules, checked every cycle, plus directed literal checks on PC loads.
module tb_pic24_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pc_inc_o, pc_load_o, imem_req_o, ir_valid_o, illegal_o;
  logic [15:0] pc_data_o;
  logic        imem_ack_i = 1'b0;
  logic [23:0] imem_rdata_i = '0;
  logic [23:0] ir_o;
  logic        stall_i = 1'b0;
  logic [2:0]  state_o;
  logic [23:0] m_pc = '0;

  always #5 clk_i = ~clk_i;

  pic24_fetch_sequencer #(
    .RESET_VECTOR(16'h0000),
    .GOTO_OPC    (8'h04),
    .BRA_OPC     (8'h37)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_addr_i(m_pc),
    .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o), .pc_data_o(pc_data_o),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .ir_o(ir_o), .ir_valid_o(ir_valid_o), .stall_i(stall_i),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model: exactly one "what happens next" flag is true at a time.
  bit        m_need_vec = 1, m_want_instr = 0, m_have_instr = 0, m_want_target = 0, m_have_target = 0;
  bit        n_need_vec, n_want_instr, n_have_instr, n_want_target, n_have_target;
  logic [23:0] m_ir = '0, n_ir;
  logic [15:0] m_target = '0, n_target;
  bit        m_ill = 0, n_ill;
  bit        pend = 0, n_pop;
  bit        e_inc, e_load, e_req;
  logic [15:0] e_data;

  logic [23:0] prog[$];
  logic [15:0] dut_loads[$], model_loads[$];
  logic        dut_ill_at_load[$];
  int          inc_count = 0;
  int          ack_mode = 0, ack_wait = 0, stall_mode = 0;
  bit          rand_data = 0;

  function automatic logic [23:0] rand_word();
    logic [7:0] op;
    int unsigned r;
    r = $urandom_range(0, 9);
    op = 8'($urandom);
    if (op == 8'h04 || op == 8'h37) op = 8'h00;
    if (r < 4)      return {op, 16'($urandom)};
    else if (r < 7) return {8'h37, 16'($urandom)};
    else if (r < 9) return {8'h04, 16'($urandom)};
    else            return {16'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h80};
  endfunction

  function automatic logic [2:0] expected_code();
    if (m_need_vec)    return 3'd0;
    if (m_want_instr)  return 3'd1;
    if (m_have_instr)  return 3'd2;
    if (m_want_target) return 3'd3;
    return 3'd4;
  endfunction

  always @(negedge rst_ni) begin
    m_need_vec = 1; m_want_instr = 0; m_have_instr = 0; m_want_target = 0; m_have_target = 0;
    m_ir = '0; m_ill = 0; pend = 0;
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_inc", pc_inc_o, 0);   chk("rst_load", pc_load_o, 0);
      chk("rst_req", imem_req_o, 0); chk("rst_ir", ir_o, 0);
      chk("rst_irv", ir_valid_o, 0); chk("rst_ill", illegal_o, 0);
      chk("rst_state", state_o, 0);
    end else begin
      e_inc = 0; e_load = 0; e_req = 0; e_data = '0; n_pop = 0;
      n_need_vec = 0; n_want_instr = m_want_instr; n_have_instr = m_have_instr;
      n_want_target = m_want_target; n_have_target = 0;
      n_ir = m_ir; n_target = m_target; n_ill = m_ill;
      if (m_need_vec) begin
        e_load = 1; e_data = 16'h0000; n_want_instr = 1;
      end else if (m_want_instr) begin
        e_req = 1;
        if (imem_ack_i) begin n_ir = imem_rdata_i; n_want_instr = 0; n_have_instr = 1; n_pop = 1; end
      end else if (m_have_instr) begin
        if (!stall_i) begin
          n_have_instr = 0;
          if (m_ir[23:16] == 8'h37) begin
            int off, tgt;
            off = int'($signed(m_ir[15:0]));
            tgt = (int'(m_pc[15:0]) + 2 + 2 * off) & 32'hFFFF;
            e_load = 1; e_data = tgt[15:0]; n_want_instr = 1;
          end else if (m_ir[23:16] == 8'h04) begin
            e_inc = 1; n_target = m_ir[15:0] & 16'hFFFE; n_want_target = 1;
          end else begin
            e_inc = 1; n_want_instr = 1;
          end
        end
      end else if (m_want_target) begin
        e_req = 1;
        if (imem_ack_i) begin
          if (imem_rdata_i % 128 != 0) n_ill = 1;
          n_want_target = 0; n_have_target = 1; n_pop = 1;
        end
      end else begin
        e_load = 1; e_data = m_target; n_want_instr = 1;
      end
      chk("pc_inc", pc_inc_o, e_inc);
      chk("pc_load", pc_load_o, e_load);
      if (e_load) chk("pc_data", pc_data_o, e_data);
      chk("imem_req", imem_req_o, e_req);
      chk("ir", ir_o, m_ir);
      chk("ir_valid", ir_valid_o, m_have_instr);
      chk("illegal", illegal_o, m_ill);
      chk("state", state_o, expected_code());
      chk("inc_load_excl", pc_inc_o & pc_load_o, 0);
      if (pc_load_o) begin dut_loads.push_back(pc_data_o); dut_ill_at_load.push_back(illegal_o); end
      if (e_load) model_loads.push_back(e_data);
      if (pc_inc_o) inc_count++;
      pend = 1;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && pend) begin
      if (e_load)     m_pc = {8'h00, e_data};
      else if (e_inc) m_pc = m_pc + 24'd2;
      m_need_vec = n_need_vec; m_want_instr = n_want_instr; m_have_instr = n_have_instr;
      m_want_target = n_want_target; m_have_target = n_have_target;
      m_ir = n_ir; m_target = n_target; m_ill = n_ill;
      if (n_pop && prog.size() > 0) void'(prog.pop_front());
      pend = 0;
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (ack_mode == 2) imem_ack_i = 0;
    else if (ack_wait > 0) begin imem_ack_i = 0; ack_wait--; end
    else if (ack_mode == 0) imem_ack_i = 1;
    else imem_ack_i = ($urandom_range(0, 2) != 0);
    if (prog.size() > 0) imem_rdata_i = prog[0];
    else imem_rdata_i = rand_data ? rand_word() : 24'h000000;
    if (stall_mode == 1)      stall_i = 1;
    else if (stall_mode == 2) stall_i = ($urandom_range(0, 3) == 0);
    else                      stall_i = 0;
  end

  task automatic release_reset();
    @(posedge clk_i); #2;
    rst_ni = 1;
  endtask

  initial begin
    logic [15:0] exp_loads[6];
    int n_inc, n_load, cnt, t;
    bit hit;
    exp_loads = '{16'h0000, 16'h0100, 16'h00FC, 16'h0100, 16'h0122, 16'h1234};
    prog = '{24'h040100, 24'h000000, 24'h37FFFD, 24'h040100, 24'h000000,
             24'h370010, 24'h041234, 24'h000001};
    repeat (3) @(posedge clk_i);
    release_reset();

    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      if (prog.size() == 0) begin hit = 1; break; end
    end
    chk("directed_drain_timeout", hit, 1);
    repeat (3) @(posedge clk_i);
    chk("load_count", dut_loads.size() >= 6, 1);
    while (dut_loads.size() < 6) begin dut_loads.push_back(16'hDEAD); dut_ill_at_load.push_back(1'bx); end
    while (model_loads.size() < 6) model_loads.push_back(16'hDEAD);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("dut_load%0d", i), dut_loads[i], exp_loads[i]);
      chk($sformatf("model_load%0d", i), model_loads[i], exp_loads[i]);
    end
    chk("ill_after_goto_ok", dut_ill_at_load[1], 0);
    chk("ill_after_goto_bad", dut_ill_at_load[5], 1);
    @(negedge clk_i);
    chk("ill_sticky", illegal_o, 1);

    @(posedge clk_i); #2;
    n_inc = inc_count; n_load = dut_loads.size();
    repeat (20) @(posedge clk_i);
    #2;
    chk("nop_inc_rate", inc_count - n_inc, 10);
    chk("nop_no_load", dut_loads.size() - n_load, 0);

    stall_mode = 1;
    repeat (4) @(posedge clk_i);
    #2;
    n_inc = inc_count; n_load = dut_loads.size();
    repeat (5) @(posedge clk_i);
    #2;
    chk("stall_no_inc", inc_count - n_inc, 0);
    chk("stall_no_load", dut_loads.size() - n_load, 0);
    chk("stall_irv", ir_valid_o, 1);
    stall_mode = 0; stall_i = 0;
    @(negedge clk_i);
    chk("stall_release_inc", pc_inc_o, 1);

    prog = '{24'h040200, 24'h000000};
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #2;
      if (m_have_instr && m_ir == 24'h040200) begin hit = 1; break; end
    end
    chk("goto_wait_timeout", hit, 1);
    ack_mode = 2;
    repeat (3) @(posedge clk_i);
    #3;
    chk("in_fetch2", m_want_target, 1);
    rst_ni = 0;
    #1;
    chk("async_inc", pc_inc_o, 0);  chk("async_load", pc_load_o, 0);
    chk("async_req", imem_req_o, 0); chk("async_ir", ir_o, 0);
    chk("async_state", state_o, 0);
    prog = '{24'h000000};
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1; ack_mode = 0; ack_wait = 3;
    @(negedge clk_i);
    chk("restart_load", pc_load_o, 1);
    chk("restart_vec", pc_data_o, 16'h0000);
    cnt = 0; hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ir_valid_o) begin hit = 1; break; end
      if (imem_req_o) cnt++;
    end
    chk("delayed_ack_timeout", hit, 1);
    chk("delayed_ack_req_cycles", cnt, 4);

    rand_data = 1; ack_mode = 1; stall_mode = 2;
    t = $urandom_range(300, 900);
    repeat (t) @(posedge clk_i);
    #3; rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #2; rst_ni = 1;
    repeat (1500 - t) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
